// File: rtl/uart_tx_param.sv
// uart_tx_param: LSB-first async UART serialiser; 1-cycle accept-to-start-bit latency; parity bit via UART_TX_PARITY_EN.
// Backpressure: o_ready is high only in IDLE, and i_valid is ignored (not queued) while a frame is on the line.
module uart_tx_param #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_signal,
  output logic                 o_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 baud_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      o_signal <= 1'b1;
      o_ready  <= 1'b1;
      o_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            state    <= S_START;
            baud_cnt <= '0;
            shreg    <= i_data;
            o_signal <= 1'b0;
            o_ready  <= 1'b0;
            o_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit  <= (^i_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          if (baud_end) begin
            state    <= S_DATA;
            bit_cnt  <= '0;
            o_signal <= shreg[0];
          end
        end
        S_DATA: begin
          if (baud_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
              state    <= S_PARITY;
              o_signal <= par_bit;
`else
              state    <= S_STOP;
              o_signal <= 1'b1;
`endif
            end else begin
              // Next bit is presented from bit 1 while the register shifts it down to bit 0.
              bit_cnt  <= bit_cnt + 1'b1;
              shreg    <= shreg >> 1;
              o_signal <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            state    <= S_STOP;
            o_signal <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= S_IDLE;
              bit_cnt <= '0;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two configurations, per-cycle check of {o_signal,o_busy,o_ready} against a frame model.
module tb_uart_tx_param;

  localparam int CA = 4, DA = 8, SA = 1, OA = 0;
  localparam int CB = 2, DB = 5, SB = 2, OB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       va, vb;
  logic [7:0] da;
  logic [4:0] db;
  logic       ra, sa, ba, rb, sb, bb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CA), .DATA_BITS(DA), .STOP_BITS(SA), .PARITY_ODD(OA)) u_a (
    .i_clock(clk), .i_reset(rst), .i_data(da), .i_valid(va),
    .o_ready(ra), .o_signal(sa), .o_busy(ba)
  );

  uart_tx_param #(.CLKS_PER_BIT(CB), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(OB)) u_b (
    .i_clock(clk), .i_reset(rst), .i_data(db), .i_valid(vb),
    .o_ready(rb), .o_signal(sb), .o_busy(bb)
  );

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s {sig,busy,rdy} got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic int clks(input int sel);  return sel ? CB : CA; endfunction
  function automatic int dbits(input int sel); return sel ? DB : DA; endfunction
  function automatic int sbits(input int sel); return sel ? SB : SA; endfunction
  function automatic int odd(input int sel);   return sel ? OB : OA; endfunction

  function automatic int flen(input int sel);
    return (1 + dbits(sel) + P + sbits(sel)) * clks(sel);
  endfunction

  // Expected line level k cycles into a frame: start, data LSB first, optional parity, stops.
  function automatic logic lvl(input int sel, input logic [8:0] w, input int k);
    int b;
    int p;
    b = k / clks(sel);
    if (b == 0) return 1'b0;
    if (b <= dbits(sel)) return w[b-1];
    if (P == 1 && b == dbits(sel) + 1) begin
      p = odd(sel);
      for (int i = 0; i < dbits(sel); i++) p = p ^ int'(w[i]);
      return p[0];
    end
    return 1'b1;
  endfunction

  function automatic logic [2:0] obs(input int sel);
    return sel ? {sb, bb, rb} : {sa, ba, ra};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [8:0] w);
    if (sel != 0) begin
      vb = v;
      db = w[4:0];
    end else begin
      va = v;
      da = w[7:0];
    end
  endtask

  // Entered at a negedge with word w already presented; optionally chains the next word or aborts by reset.
  task automatic frame(input int sel, input logic [8:0] w, input bit chain, input logic [8:0] nw,
                       input int abort_k);
    chk($sformatf("s%0d_pre", sel), obs(sel), 3'b101);
    for (int k = 0; k < flen(sel); k++) begin
      @(negedge clk);
      chk($sformatf("s%0d_w%0h_k%0d", sel, w, k), obs(sel), {lvl(sel, w, k), 2'b10});
      if (k == 0) drive(sel, chain, nw);
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        chk($sformatf("s%0d_abort", sel), obs(sel), 3'b101);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("s%0d_idle", sel), obs(sel), 3'b101);
  endtask

  initial begin
    logic [8:0] w;
    logic [8:0] nw;
    int         sel;
    bit         chain;

    // Reset asserted together with a pending word: reset wins, nothing is sent.
    rst = 1'b1;
    va  = 1'b1;
    vb  = 1'b1;
    da  = 8'h55;
    db  = 5'h15;
    repeat (3) begin
      @(negedge clk);
      chk("rst_a", obs(0), 3'b101);
      chk("rst_b", obs(1), 3'b101);
    end
    va  = 1'b0;
    vb  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold_a%0d", i), obs(0), 3'b101);
      chk($sformatf("hold_b%0d", i), obs(1), 3'b101);
    end

    drive(0, 1'b1, 9'h0A5);
    frame(0, 9'h0A5, 1'b0, 9'h000, -1);

    drive(1, 1'b1, 9'h013);
    frame(1, 9'h013, 1'b0, 9'h000, -1);

    // i_valid held high across two words: second accepted only on the idle cycle.
    drive(0, 1'b1, 9'h000);
    frame(0, 9'h000, 1'b1, 9'h0FF, -1);
    frame(0, 9'h0FF, 1'b0, 9'h000, -1);

    // Reset during data bit 3, then a clean frame.
    drive(0, 1'b1, 9'h0C6);
    frame(0, 9'h0C6, 1'b0, 9'h000, 4 * CA + 1);
    drive(0, 1'b1, 9'h03C);
    frame(0, 9'h03C, 1'b0, 9'h000, -1);

    for (int i = 0; i < 16; i++) begin
      sel   = int'($urandom_range(1, 0));
      w     = 9'($urandom);
      nw    = 9'($urandom);
      chain = 1'($urandom_range(1, 0));
      repeat ($urandom_range(3, 0)) @(negedge clk);
      drive(sel, 1'b1, w);
      frame(sel, w, chain, nw, -1);
      if (chain) frame(sel, nw, 1'b0, 9'h000, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
